// File: rtl/tuner_pkg.sv
// Shared types, default widths and small helpers for the tuner measurement sequencer.
package tuner_pkg;

  localparam int unsigned ADDR_W_DEF  = 11;
  localparam int unsigned DATA_W_DEF  = 10;
  localparam int unsigned BIN_W_DEF   = 10;
  localparam int unsigned SETTLE_DEF  = 16;
  localparam int unsigned TIMEOUT_DEF = 4_000_000;

  typedef enum logic [2:0] {
    IDLE,
    CAPTURE,
    GAP1,
    FFT,
    GAP2,
    PEAK,
    DONE
  } seq_state_t;

  typedef enum logic [1:0] {
    OWN_NONE,
    OWN_CAP,
    OWN_FFT,
    OWN_PEAK
  } mem_owner_t;

  // Bits needed for a down-counter that starts at n-1.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

  function automatic mem_owner_t owner_of(input seq_state_t s);
    case (s)
      CAPTURE: return OWN_CAP;
      FFT:     return OWN_FFT;
      PEAK:    return OWN_PEAK;
      default: return OWN_NONE;
    endcase
  endfunction

  function automatic logic is_stage(input seq_state_t s);
    return (s == CAPTURE) || (s == FFT) || (s == PEAK);
  endfunction

endpackage

// File: rtl/seq_cycle_timer.sv
// Load/count/expire down-counter; expired is high while the count sits at zero.
// Load has priority over counting; the count holds at zero until reloaded.
module seq_cycle_timer #(
  parameter int unsigned W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         count_en,
  output logic         expired
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (count_en && (cnt_q != '0)) begin
      cnt_d = cnt_q - W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired = (cnt_q == '0);

endmodule

// File: rtl/tuner_sequencer.sv
// Capture -> FFT -> peak-search scheduler and sole owner of the shared sample RAM port.
// Optional per-stage watchdog is built when TUNER_SEQ_TIMEOUT_EN is defined.
module tuner_sequencer
  import tuner_pkg::*;
#(
  parameter int unsigned ADDR_W         = ADDR_W_DEF,
  parameter int unsigned DATA_W         = DATA_W_DEF,
  parameter int unsigned BIN_W          = BIN_W_DEF,
  parameter int unsigned SETTLE_CYCLES  = SETTLE_DEF,
  parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              continuous,
  input  logic              abort,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [BIN_W-1:0]  result_bin,
  output logic              result_valid,
  output logic              cap_start,
  input  logic              cap_done,
  input  logic              cap_we,
  input  logic [ADDR_W-1:0] cap_addr,
  input  logic [DATA_W-1:0] cap_wdata,
  output logic              fft_start,
  input  logic              fft_done,
  input  logic              fft_we,
  input  logic [ADDR_W-1:0] fft_addr,
  input  logic [DATA_W-1:0] fft_wdata,
  output logic              pk_start,
  input  logic              pk_done,
  input  logic [BIN_W-1:0]  pk_bin,
  input  logic [ADDR_W-1:0] pk_addr,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata
);

  localparam int unsigned GAP_W = cnt_width(SETTLE_CYCLES);
`ifdef TUNER_SEQ_TIMEOUT_EN
  localparam int unsigned WD_W  = cnt_width(TIMEOUT_CYCLES);
  localparam int unsigned TMR_W = (WD_W > GAP_W) ? WD_W : GAP_W;
`else
  localparam int unsigned TMR_W = GAP_W;
`endif

  seq_state_t       state_q, state_d;
  mem_owner_t       owner_q, owner_d;
  logic             cap_start_q, cap_start_d;
  logic             fft_start_q, fft_start_d;
  logic             pk_start_q, pk_start_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [BIN_W-1:0] result_bin_q, result_bin_d;
  logic             result_valid_q, result_valid_d;

  logic             stage_done;
  logic             wd_fire;
  logic             tmr_load;
  logic [TMR_W-1:0] tmr_load_val;
  logic             tmr_en;
  logic             tmr_expired;

  // Gaps and stages never overlap, so one timer serves both the settle gap and the watchdog.
  seq_cycle_timer #(
    .W (TMR_W)
  ) u_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (tmr_load),
    .load_val (tmr_load_val),
    .count_en (tmr_en),
    .expired  (tmr_expired)
  );

  always_comb begin
    stage_done = 1'b0;
    case (state_q)
      CAPTURE: stage_done = cap_done;
      FFT:     stage_done = fft_done;
      PEAK:    stage_done = pk_done;
      default: stage_done = 1'b0;
    endcase
  end

`ifdef TUNER_SEQ_TIMEOUT_EN
  logic error_q, error_d;

  // A done or abort arriving on the expiry cycle takes precedence over the timeout.
  assign wd_fire = is_stage(state_q) && tmr_expired && !abort && !stage_done;

  always_comb begin
    error_d = error_q;
    if ((state_q == IDLE) && start && !abort) begin
      error_d = 1'b0;
    end else if (wd_fire) begin
      error_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      error_q <= 1'b0;
    end else begin
      error_q <= error_d;
    end
  end

  assign error = error_q;
`else
  assign wd_fire = 1'b0;
  assign error   = 1'b0;
`endif

  always_comb begin
    state_d        = state_q;
    result_bin_d   = result_bin_q;
    result_valid_d = result_valid_q;
    case (state_q)
      IDLE: begin
        if (start && !abort) state_d = CAPTURE;
      end
      CAPTURE: begin
        if (abort || wd_fire) state_d = IDLE;
        else if (cap_done)    state_d = GAP1;
      end
      GAP1: begin
        if (abort)            state_d = IDLE;
        else if (tmr_expired) state_d = FFT;
      end
      FFT: begin
        if (abort || wd_fire) state_d = IDLE;
        else if (fft_done)    state_d = GAP2;
      end
      GAP2: begin
        if (abort)            state_d = IDLE;
        else if (tmr_expired) state_d = PEAK;
      end
      PEAK: begin
        if (abort || wd_fire) begin
          state_d = IDLE;
        end else if (pk_done) begin
          state_d        = DONE;
          result_bin_d   = pk_bin;
          result_valid_d = 1'b1;
        end
      end
      DONE: begin
        if (abort)           state_d = IDLE;
        else if (continuous) state_d = CAPTURE;
        else                 state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Timer is loaded on the edge that enters a gap (or a stage) so it counts from that state's first cycle.
  always_comb begin
    tmr_load     = 1'b0;
    tmr_load_val = TMR_W'(SETTLE_CYCLES - 1);
    tmr_en       = (state_q == GAP1) || (state_q == GAP2);
    if (state_d != state_q) begin
      if ((state_d == GAP1) || (state_d == GAP2)) begin
        tmr_load = 1'b1;
      end
`ifdef TUNER_SEQ_TIMEOUT_EN
      else if (is_stage(state_d)) begin
        tmr_load     = 1'b1;
        tmr_load_val = TMR_W'(TIMEOUT_CYCLES - 1);
      end
`endif
    end
`ifdef TUNER_SEQ_TIMEOUT_EN
    tmr_en = tmr_en || is_stage(state_q);
`endif
  end

  always_comb begin
    owner_d     = owner_of(state_d);
    cap_start_d = (state_d == CAPTURE) && (state_q != CAPTURE);
    fft_start_d = (state_d == FFT)     && (state_q != FFT);
    pk_start_d  = (state_d == PEAK)    && (state_q != PEAK);
    busy_d      = (state_d != IDLE);
    done_d      = (state_d == DONE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= IDLE;
      owner_q        <= OWN_NONE;
      cap_start_q    <= 1'b0;
      fft_start_q    <= 1'b0;
      pk_start_q     <= 1'b0;
      busy_q         <= 1'b0;
      done_q         <= 1'b0;
      result_bin_q   <= '0;
      result_valid_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      owner_q        <= owner_d;
      cap_start_q    <= cap_start_d;
      fft_start_q    <= fft_start_d;
      pk_start_q     <= pk_start_d;
      busy_q         <= busy_d;
      done_q         <= done_d;
      result_bin_q   <= result_bin_d;
      result_valid_q <= result_valid_d;
    end
  end

  // Mux keyed on the registered owner: a reset clears it at once, which drops mem_we without a clock.
  always_comb begin
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    case (owner_q)
      OWN_CAP: begin
        mem_we    = cap_we;
        mem_addr  = cap_addr;
        mem_wdata = cap_wdata;
      end
      OWN_FFT: begin
        mem_we    = fft_we;
        mem_addr  = fft_addr;
        mem_wdata = fft_wdata;
      end
      OWN_PEAK: begin
        mem_addr  = pk_addr;
      end
      default: ;
    endcase
  end

  assign busy         = busy_q;
  assign done         = done_q;
  assign result_bin   = result_bin_q;
  assign result_valid = result_valid_q;
  assign cap_start    = cap_start_q;
  assign fft_start    = fft_start_q;
  assign pk_start     = pk_start_q;

endmodule
